// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory arbiter and its address checker.
package imem_pkg;

    localparam int          DEFAULT_ADDR_W = 10;
    localparam logic [31:0] NOP_INSN       = 32'h00000013;

    typedef enum logic [0:0] {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/imem_addr_check.sv
// Combinational word-alignment and range check for a byte address into a 2^ADDR_W-word memory.
module imem_addr_check #(
    parameter int ADDR_W = 10
) (
    input  logic [31:0] addr_i,
    output logic        misaligned_o,
    output logic        out_of_range_o,
    output logic        fault_o
);

    assign misaligned_o   = |addr_i[1:0];
    assign out_of_range_o = |addr_i[31:ADDR_W+2];
    assign fault_o        = misaligned_o | out_of_range_o;

endmodule

// File: rtl/imem_arbiter.sv
// Shares a single-port instruction RAM between the fetch port and the program loader;
// holds the core during BOOT, then gives fetch priority with bounded loader starvation.
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int ADDR_W     = DEFAULT_ADDR_W,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              boot_done,
    output logic              core_hold,
    input  logic              fetch_req,
    input  logic [31:0]       fetch_addr,
    output logic              fetch_gnt,
    output logic              fetch_valid,
    output logic [31:0]       fetch_data,
    output logic              fetch_fault,
    input  logic              load_req,
    input  logic              load_we,
    input  logic [31:0]       load_addr,
    input  logic [31:0]       load_wdata,
    output logic              load_gnt,
    output logic              load_valid,
    output logic [31:0]       load_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   starve_q, starve_d;
    logic               fetch_valid_q, fetch_fault_q, load_valid_q;
    logic [31:0]        fetch_hold_q, load_hold_q;

    logic fetch_sel, load_sel, load_rd;
    logic fetch_bad, fetch_misaligned, fetch_oor;
    logic unused_ok;

    imem_addr_check #(.ADDR_W(ADDR_W)) u_fetch_check (
        .addr_i         (fetch_addr),
        .misaligned_o   (fetch_misaligned),
        .out_of_range_o (fetch_oor),
        .fault_o        (fetch_bad)
    );

    // Loader ignores the byte-lane and high address bits.
    assign unused_ok = ^{load_addr[31:ADDR_W+2], load_addr[1:0], fetch_misaligned, fetch_oor};

    // Grants are gated by rst so every output sits at its reset value while reset is held.
    always_comb begin
        load_sel  = 1'b0;
        fetch_sel = 1'b0;
        if (rst) begin
            if (state_q == BOOT) begin
                load_sel = load_req;
            end else begin
                load_sel  = load_req && (!fetch_req || starve_q == CNT_W'(STARVE_MAX));
                fetch_sel = fetch_req && !load_sel;
            end
        end
    end

    assign load_rd  = load_sel && !load_we;
    assign starve_d = (state_q == RUN && load_req && !load_sel) ? starve_q + 1'b1 : '0;
    // A read granted this cycle still owes a response, so BOOT is held one more edge.
    assign state_d  = (state_q == BOOT && boot_done && !load_rd) ? RUN : state_q;

    assign fetch_gnt = fetch_sel;
    assign load_gnt  = load_sel;
    assign core_hold = (state_q == BOOT);

    assign mem_en    = load_sel | (fetch_sel & ~fetch_bad);
    assign mem_we    = load_sel & load_we;
    assign mem_addr  = load_sel ? load_addr[ADDR_W+1:2] : fetch_addr[ADDR_W+1:2];
    assign mem_wdata = load_sel ? load_wdata : '0;

    assign fetch_valid = fetch_valid_q;
    assign fetch_fault = fetch_fault_q;
    assign fetch_data  = fetch_valid_q ? (fetch_fault_q ? NOP_INSN : mem_rdata) : fetch_hold_q;
    assign load_valid  = load_valid_q;
    assign load_rdata  = load_valid_q ? mem_rdata : load_hold_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= BOOT;
            starve_q      <= '0;
            fetch_valid_q <= 1'b0;
            fetch_fault_q <= 1'b0;
            fetch_hold_q  <= '0;
            load_valid_q  <= 1'b0;
            load_hold_q   <= '0;
        end else begin
            state_q       <= state_d;
            starve_q      <= starve_d;
            fetch_valid_q <= fetch_sel;
            load_valid_q  <= load_rd;
            if (fetch_sel) begin
                fetch_fault_q <= fetch_bad;
            end
            if (fetch_valid_q) begin
                fetch_hold_q <= fetch_data;
            end
            if (load_valid_q) begin
                load_hold_q <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a behavioural RAM and a response scoreboard.
module tb_imem_arbiter;
    import imem_pkg::*;

    localparam int AW = 10;
    localparam int SM = 4;

    typedef struct {
        logic [31:0] data;
        logic        fault;
    } resp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          boot_done, core_hold;
    logic          fetch_req, fetch_gnt, fetch_valid, fetch_fault;
    logic [31:0]   fetch_addr, fetch_data;
    logic          load_req, load_we, load_gnt, load_valid;
    logic [31:0]   load_addr, load_wdata, load_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata = '0;

    logic [31:0] ram   [0:(1<<AW)-1];
    logic [31:0] model [0:(1<<AW)-1];
    resp_t       fq[$];
    logic [31:0] lq[$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    imem_arbiter #(.ADDR_W(AW), .STARVE_MAX(SM)) dut (
        .clk         (clk),
        .rst         (rst),
        .boot_done   (boot_done),
        .core_hold   (core_hold),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_gnt   (fetch_gnt),
        .fetch_valid (fetch_valid),
        .fetch_data  (fetch_data),
        .fetch_fault (fetch_fault),
        .load_req    (load_req),
        .load_we     (load_we),
        .load_addr   (load_addr),
        .load_wdata  (load_wdata),
        .load_gnt    (load_gnt),
        .load_valid  (load_valid),
        .load_rdata  (load_rdata),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit is_fault(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:AW+2] != '0);
    endfunction

    task automatic check_resp(input string tag);
        resp_t       r;
        logic [31:0] d;
        chk(fetch_valid, fq.size() != 0, {tag, ":fvalid"});
        if (fq.size() != 0) begin
            r = fq.pop_front();
            chk(fetch_data, r.data, {tag, ":fdata"});
            chk(fetch_fault, r.fault, {tag, ":ffault"});
        end
        chk(load_valid, lq.size() != 0, {tag, ":lvalid"});
        if (lq.size() != 0) begin
            d = lq.pop_front();
            chk(load_rdata, d, {tag, ":ldata"});
        end
    endtask

    // One clock cycle: drive, check responses and grants at the falling edge, record expectations.
    task automatic cyc(input bit fr, input logic [31:0] fa, input bit lr, input bit lw,
                       input logic [31:0] la, input logic [31:0] wd, input bit bd,
                       input bit efg, input bit elg, input string tag);
        resp_t r;
        fetch_req  = fr;
        fetch_addr = fa;
        load_req   = lr;
        load_we    = lw;
        load_addr  = la;
        load_wdata = wd;
        boot_done  = bd;
        @(negedge clk);
        check_resp(tag);
        chk(fetch_gnt, efg, {tag, ":fgnt"});
        chk(load_gnt, elg, {tag, ":lgnt"});
        chk(mem_en, (efg && !is_fault(fa)) || elg, {tag, ":mem_en"});
        if (efg) begin
            r.fault = is_fault(fa);
            r.data  = r.fault ? 32'h00000013 : model[fa[AW+1:2]];
            fq.push_back(r);
        end
        if (elg) begin
            if (lw) model[la[AW+1:2]] = wd;
            else    lq.push_back(model[la[AW+1:2]]);
        end
        $display("cycle %-16s fgnt=%0d lgnt=%0d mem_en=%0d fvalid=%0d lvalid=%0d hold=%0d",
                 tag, fetch_gnt, load_gnt, mem_en, fetch_valid, load_valid, core_hold);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            ram[i]   = '0;
            model[i] = '0;
        end
        fetch_req = 1'b1; fetch_addr = '0; load_req = 1'b0; load_we = 1'b0;
        load_addr = '0; load_wdata = '0; boot_done = 1'b0;

        @(negedge clk);
        chk(core_hold, 1, "rst:hold");
        chk(fetch_gnt, 0, "rst:fgnt");
        chk(load_gnt, 0, "rst:lgnt");
        chk(mem_en, 0, "rst:mem_en");
        chk(fetch_valid, 0, "rst:fvalid");
        chk(fetch_data, 0, "rst:fdata");
        @(posedge clk);
        #1;
        rst = 1'b1;

        cyc(1, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 0, "boot_fetch");
        chk(core_hold, 1, "boot:hold");
        cyc(0, 32'h0, 1, 1, 32'h0, 32'h00108093, 0, 0, 1, "ld_w0");
        cyc(0, 32'h0, 1, 1, 32'h4, 32'h00210113, 0, 0, 1, "ld_w4");
        cyc(0, 32'h0, 1, 1, 32'h9, 32'h00318193, 0, 0, 1, "ld_w8");
        cyc(0, 32'h0, 1, 1, 32'hC, 32'h00418213, 0, 0, 1, "ld_wC");
        cyc(0, 32'h0, 1, 0, 32'h0, 32'h0, 1, 0, 1, "ld_r0_bd");
        chk(core_hold, 1, "pend:hold");
        cyc(0, 32'h0, 0, 0, 32'h0, 32'h0, 1, 0, 0, "ld_resp");
        chk(core_hold, 0, "run:hold");
        cyc(0, 32'h0, 0, 0, 32'h0, 32'h0, 1, 0, 0, "run_idle");
        chk(load_rdata, 32'h00108093, "ld_held");

        cyc(1, 32'h0, 0, 0, 32'h0, 32'h0, 1, 1, 0, "f0");
        cyc(1, 32'h4, 0, 0, 32'h0, 32'h0, 1, 1, 0, "f4");
        cyc(1, 32'h8, 0, 0, 32'h0, 32'h0, 1, 1, 0, "f8");
        cyc(0, 32'h0, 0, 0, 32'h0, 32'h0, 1, 0, 0, "f_drain");
        chk(fetch_data, 32'h00318193, "f_held");

        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < SM; i++)
                cyc(1, 32'h0, 1, 0, 32'h4, 32'h0, 1, 1, 0, "starve_f");
            cyc(1, 32'h0, 1, 0, 32'h4, 32'h0, 1, 0, 1, "starve_ld");
        end
        cyc(1, 32'h0, 1, 0, 32'h8, 32'h0, 1, 1, 0, "clr_f");
        cyc(1, 32'h0, 1, 0, 32'h8, 32'h0, 1, 1, 0, "clr_f");
        cyc(1, 32'h0, 0, 0, 32'h8, 32'h0, 1, 1, 0, "clr_noload");
        for (int i = 0; i < SM; i++)
            cyc(1, 32'h4, 1, 0, 32'h8, 32'h0, 1, 1, 0, "restart_f");
        cyc(1, 32'h4, 1, 0, 32'h8, 32'h0, 1, 0, 1, "restart_ld");

        cyc(0, 32'h0, 1, 1, 32'h4, 32'hDEADBEEF, 1, 0, 1, "run_w4");
        cyc(1, 32'h4, 0, 0, 32'h0, 32'h0, 1, 1, 0, "f4_new");

        cyc(1, 32'h2, 0, 0, 32'h0, 32'h0, 1, 1, 0, "f_misal");
        cyc(1, 32'h1000, 0, 0, 32'h0, 32'h0, 1, 1, 0, "f_range");
        cyc(1, 32'h8, 0, 0, 32'h0, 32'h0, 1, 1, 0, "f_ok");
        cyc(0, 32'h0, 0, 0, 32'h0, 32'h0, 1, 0, 0, "f_drain2");

        cyc(1, 32'hC, 0, 0, 32'h0, 32'h0, 1, 1, 0, "f_pre_rst");
        rst = 1'b0;
        fq.delete();
        #2;
        chk(fetch_valid, 0, "midrst:fvalid");
        chk(core_hold, 1, "midrst:hold");
        chk(fetch_gnt, 0, "midrst:fgnt");
        chk(fetch_data, 0, "midrst:fdata");
        @(negedge clk);
        chk(fetch_valid, 0, "midrst:fvalid2");
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc(1, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 0, "post_rst_boot");
        chk(fq.size(), 0, "end:fq_empty");
        chk(lq.size(), 0, "end:lq_empty");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Sequencing and arbitration controller for the single-port, word-organised instruction memory. Shares the memory between the core's fetch port and a program-loader port. Holds the core in reset-like stall until loading completes, then gives fetch priority with bounded loader starvation. Sits between the IF stage and a synchronous instruction RAM with one-cycle read latency.

## Interface
- ADDR_W, 10, word-address width (2^ADDR_W words; 10 gives 1024 words)
- STARVE_MAX, 4, consecutive fetch grants allowed while a loader request waits
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- boot_done  in  1  loader finished; level-sensitive, sampled each cycle
- core_hold  out  1  high while in BOOT; core must not advance PC
- fetch_req  in  1  fetch request
- fetch_addr  in  32  byte address
- fetch_gnt  out  1  request accepted this cycle (combinational)
- fetch_valid  out  1  response valid (registered)
- fetch_data  out  32  instruction word
- fetch_fault  out  1  address misaligned or out of range
- load_req  in  1  loader request
- load_we  in  1  1 = write, 0 = read-back
- load_addr  in  32  byte address
- load_wdata  in  32  write data
- load_gnt  out  1  request accepted this cycle (combinational)
- load_valid  out  1  read-back response valid (registered)
- load_rdata  out  32  read-back data
- mem_en, mem_we  out  1  RAM enable / write enable
- mem_addr  out  ADDR_W  RAM word address = byte_addr[ADDR_W+1:2]
- mem_wdata  out  32  RAM write data
- mem_rdata  in  32  RAM read data, valid one cycle after mem_en with mem_we=0

## Operation
- States: BOOT, RUN.
- Reset: state BOOT, core_hold=1. All other outputs 0. Starvation counter 0. Pending-response flags cleared.
- BOOT: only loader is served; fetch_gnt=0. BOOT→RUN when boot_done=1 and no load response is pending. core_hold falls the same edge.
- RUN:
  - fetch wins by default.
  - Each fetch grant while load_req=1 increments the counter.
  - When counter==STARVE_MAX and load_req=1, the loader is granted instead and the counter clears.
  - The counter also clears on any cycle with load_req=0.
- RUN never returns to BOOT except via reset.
- At most one grant per cycle. A requester must hold req and addr stable until it sees gnt.
- Fetch fault (addr[1:0]!=0 or any bit above ADDR_W+1 set):
  - grant given, mem_en stays 0
  - next cycle: fetch_valid=1, fetch_fault=1, fetch_data=32'h00000013 (NOP)
- Loader addresses:
  - Low two bits and high bits ignored.
  - Writes produce no response.
  - Reads produce load_valid.
- fetch_valid and load_valid are single-cycle pulses. Response data is held until the next response.

## Timing
- Grant is combinational in the request cycle. mem_* outputs are driven the same cycle.
- Read response arrives exactly one cycle after grant: fetch_valid/load_valid rise and data = mem_rdata.
- Back-to-back fetch gives one instruction per cycle.
- Write to address A in cycle N, fetch of A in cycle N+1: returns the new data (RAM write-first is not needed).
- Simultaneous fetch_req and load_req in RUN: fetch wins unless starvation limit reached.
- Async reset mid-access: a response due next cycle is dropped. Outputs go to reset values immediately.

## Structure
- Shared package `imem_pkg`:
  - state enum {BOOT, RUN}
  - NOP constant 32'h00000013
  - default ADDR_W
- One natural sub-module: `imem_addr_check` (combinational alignment/range check, reused by the future data-memory controller).
- Everything else is flat.
- Target: 150–250 lines.

## Test plan
- Reset, then fetch_req=1 with boot_done=0 → fetch_gnt=0, core_hold=1. After release, mem_en=0.
- BOOT: loader writes 0x00108093 to byte 0x0 and reads it back → load_valid one cycle after grant, load_rdata=0x00108093. Raise boot_done → core_hold=0 next edge.
- RUN: fetch 0x0, 0x4, 0x8 on consecutive cycles → three consecutive fetch_valid pulses with matching data, no bubbles.
- RUN, STARVE_MAX=4: fetch_req and load_req held high → loader granted on 5th cycle, then fetch resumes. Counter restarts.
- fetch_addr=0x2, then 0x1000 (ADDR_W=10) → each gives fetch_valid with fault=1, data=0x00000013, mem_en=0.
- Assert rst in the cycle after a fetch grant → no fetch_valid. State BOOT, core_hold=1 immediately.
